// File: rtl/rpn_sequencer.sv
// Drives a stack ALU through one postfix expression at a time, tracking stack depth and errors.
// Optional feature: define RPN_CYCLE_COUNT_EN to add the cyc_count busy-cycle counter output.
module rpn_sequencer #(
  parameter  int N     = 8,
  parameter  int DEPTH = 8,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic [1:0]    tok_type,
  input  logic [N-1:0]  tok_data,
  output logic [2:0]    alu_opcode,
  output logic [N-1:0]  alu_data,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_ovf,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          res_ovf,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [DW-1:0] depth
`ifdef RPN_CYCLE_COUNT_EN
  ,
  output logic [15:0]   cyc_count
`endif
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] TOK_OPND = 2'b00;
  localparam logic [1:0] TOK_ADD  = 2'b01;
  localparam logic [1:0] TOK_MUL  = 2'b10;
  localparam logic [1:0] TOK_END  = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_FULL  = 2'b10;
  localparam logic [1:0] ERR_END   = 2'b11;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  typedef enum logic [3:0] {
    S_FETCH, S_PUSH, S_EVAL, S_POP_A, S_POP_B, S_PUSH_R, S_FINAL, S_DONE, S_ERR, S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [N-1:0]  opnd_q, opnd_d;
  logic [N-1:0]  tmp_q, tmp_d;
  logic          is_mul_q, is_mul_d;
  logic [N-1:0]  res_data_q, res_data_d;
  logic          res_ovf_q, res_ovf_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          accept;

  assign tok_ready = (state_q == S_FETCH) && !clear && !rst;
  assign accept    = tok_valid && tok_ready;

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    state_d    = state_q;
    depth_d    = depth_q;
    opnd_d     = opnd_q;
    tmp_d      = tmp_q;
    is_mul_d   = is_mul_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    err_code_d = err_code_q;
    alu_opcode = OP_NOP;
    alu_data   = '0;

    case (state_q)
      S_FETCH: begin
        if (accept) begin
          case (tok_type)
            TOK_OPND: begin
              if (depth_q == DEPTH_MAX) begin
                state_d    = S_ERR;
                err_code_d = ERR_FULL;
              end else begin
                opnd_d  = tok_data;
                state_d = S_PUSH;
              end
            end
            TOK_ADD, TOK_MUL: begin
              if (depth_q < TWO) begin
                state_d    = S_ERR;
                err_code_d = ERR_UNDER;
              end else begin
                is_mul_d = (tok_type == TOK_MUL);
                state_d  = S_EVAL;
              end
            end
            default: begin
              if (depth_q != ONE) begin
                state_d    = S_ERR;
                err_code_d = ERR_END;
              end else begin
                state_d = S_FINAL;
              end
            end
          endcase
        end
      end
      S_PUSH: begin
        alu_opcode = OP_PUSH;
        alu_data   = opnd_q;
        depth_d    = depth_q + ONE;
        state_d    = S_FETCH;
      end
      S_EVAL: begin
        alu_opcode = is_mul_q ? OP_MUL : OP_ADD;
        tmp_d      = alu_result;
        res_ovf_d  = res_ovf_q | alu_ovf;
        state_d    = S_POP_A;
      end
      S_POP_A: begin
        alu_opcode = OP_POP;
        depth_d    = depth_q - ONE;
        state_d    = S_POP_B;
      end
      S_POP_B: begin
        alu_opcode = OP_POP;
        depth_d    = depth_q - ONE;
        state_d    = S_PUSH_R;
      end
      S_PUSH_R: begin
        alu_opcode = OP_PUSH;
        alu_data   = tmp_q;
        depth_d    = depth_q + ONE;
        state_d    = S_FETCH;
      end
      S_FINAL: begin
        alu_opcode = OP_POP;
        res_data_d = alu_result;
        depth_d    = '0;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_ovf_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_ERR: state_d = S_ERR;
      S_DRAIN: begin
        // Exactly one pop per occupied slot; return to FETCH on the last one.
        if (depth_q != '0) begin
          alu_opcode = OP_POP;
          depth_d    = depth_q - ONE;
        end
        if (depth_q <= ONE) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // The ALU still executes this cycle's opcode, so drain from the post-operation depth.
    if (clear && state_q != S_DRAIN) begin
      state_d    = (depth_d == '0) ? S_FETCH : S_DRAIN;
      err_code_d = ERR_NONE;
      res_ovf_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      depth_q    <= '0;
      opnd_q     <= '0;
      tmp_q      <= '0;
      is_mul_q   <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      opnd_q     <= opnd_d;
      tmp_q      <= tmp_d;
      is_mul_q   <= is_mul_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      err_code_q <= err_code_d;
    end
  end

  assign res_valid = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign err_code  = err_code_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign depth     = depth_q;

`ifdef RPN_CYCLE_COUNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (clear && state_q != S_DRAIN) begin
      cyc_d = '0;
    end else if (state_q == S_DONE) begin
      if (res_ready) cyc_d = '0;
    end else if (state_q != S_ERR && !(state_q == S_FETCH && !accept)) begin
      if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cyc_count = cyc_q;
`endif

endmodule

// File: tb/tb_rpn_sequencer.sv
// Random and directed postfix expressions against a same-cycle stack ALU model,
// with expected values taken from a queue-based evaluator of the expression rules.
module tb_rpn_sequencer;
  localparam int N     = 8;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk, rst, clear, tok_valid, tok_ready;
  logic [1:0]    tok_type;
  logic [N-1:0]  tok_data;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_data, alu_result;
  logic          alu_ovf;
  logic          res_valid, res_ready, res_ovf, err;
  logic [N-1:0]  res_data;
  logic [1:0]    err_code;
  logic [DW-1:0] depth;

  rpn_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_data(tok_data),
    .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .err(err), .err_code(err_code), .depth(depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stack ALU: ADD/MUL read the top two entries without popping; PUSH/POP move the stack.
  logic [N-1:0] stk [DEPTH];
  int sp = 0;
  int alu_bad = 0;
  int alu_s;

  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    alu_s      = 0;
    case (alu_opcode)
      3'b100, 3'b101: if (sp >= 2) begin
        if (alu_opcode == 3'b100) alu_s = int'($signed(stk[sp-2])) + int'($signed(stk[sp-1]));
        else                      alu_s = int'($signed(stk[sp-2])) * int'($signed(stk[sp-1]));
        alu_result = alu_s[7:0];
        alu_ovf    = (alu_s > 127) || (alu_s < -128);
      end
      3'b111: if (sp >= 1) alu_result = stk[sp-1];
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
    end else begin
      case (alu_opcode)
        3'b000: ;
        3'b110: if (sp < DEPTH) begin stk[sp] <= alu_data; sp <= sp + 1; end
                else alu_bad <= alu_bad + 1;
        3'b111: if (sp > 0) sp <= sp - 1; else alu_bad <= alu_bad + 1;
        3'b100, 3'b101: if (sp < 2) alu_bad <= alu_bad + 1;
        default: alu_bad <= alu_bad + 1;
      endcase
    end
  end

  typedef struct { logic [1:0] t; logic [7:0] d; } tok_t;
  typedef struct { int stop; logic [1:0] code; logic [7:0] result; logic ovf; int depth; } exp_t;

  function automatic tok_t mk(input logic [1:0] t, input int v);
    tok_t k;
    k.t = t;
    k.d = 8'(v);
    return k;
  endfunction

  // Reference evaluator: plain integer stack, stops at the first token that errors or ends.
  function automatic exp_t model(input tok_t q[$]);
    exp_t e;
    int st[$];
    int a, b, r;
    logic [7:0] w;
    e.stop = q.size() - 1; e.code = 2'b00; e.result = '0; e.ovf = 1'b0; e.depth = 0;
    foreach (q[i]) begin
      if (q[i].t == 2'b00) begin
        if (st.size() == DEPTH) begin
          e.stop = i; e.code = 2'b10; e.depth = st.size(); return e;
        end
        st.push_back(int'($signed(q[i].d)));
      end else if (q[i].t == 2'b11) begin
        e.stop = i;
        if (st.size() != 1) begin e.code = 2'b11; e.depth = st.size(); end
        else begin w = 8'(st[0]); e.result = w; e.depth = 0; end
        return e;
      end else begin
        if (st.size() < 2) begin
          e.stop = i; e.code = 2'b01; e.depth = st.size(); return e;
        end
        b = st.pop_back();
        a = st.pop_back();
        r = (q[i].t == 2'b01) ? a + b : a * b;
        if (r > 127 || r < -128) e.ovf = 1'b1;
        w = r[7:0];
        st.push_back(int'($signed(w)));
      end
    end
    e.depth = st.size();
    return e;
  endfunction

  task automatic send(input tok_t tk);
    int b;
    b = 0;
    tok_type = tk.t; tok_data = tk.d; tok_valid = 1'b1;
    #1;
    while (!tok_ready && b < 100) begin @(negedge clk); #1; b++; end
    if (!tok_ready) check("send_timeout", 32'(tok_ready), 1);
    @(posedge clk);
    #1 tok_valid = 1'b0;
    tok_type = 2'($urandom_range(0, 3)); tok_data = 8'($urandom_range(0, 255));
  endtask

  task automatic do_clear(input int exp_pops);
    int n;
    n = 0;
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (alu_opcode == 3'b111) n++;
      else break;
    end
    check("drain_pops", n, exp_pops);
    check("drain_depth", 32'(depth), 0);
    check("drain_err", {err, err_code}, 0);
    check("drain_ready", 32'(tok_ready), 1);
    check("drain_alu_sp", sp, 0);
  endtask

  task automatic run_expr(input tok_t q[$], input int hold);
    exp_t e;
    int n;
    logic ok;
    e = model(q);
    for (int i = 0; i <= e.stop; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(q[i]);
      if (i == e.stop && e.code != 2'b00) begin
        repeat (2) @(negedge clk);
        check("err_flag", 32'(err), 1);
        check("err_code", 32'(err_code), 32'(e.code));
        check("err_depth", 32'(depth), e.depth);
        check("err_ready", 32'(tok_ready), 0);
        check("err_alu_sp", sp, e.depth);
        do_clear(e.depth);
      end else if (q[i].t == 2'b11) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 20);
        check("end_latency", n, 2);
        check("res_data", 32'(res_data), 32'(e.result));
        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
        check("done_err", 32'(err), 0);
        check("done_depth", 32'(depth), 0);
        check("done_alu_sp", sp, 0);
        ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          if (!res_valid || res_data !== e.result || tok_ready) ok = 1'b0;
        end
        check("done_hold", 32'(ok), 1);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("release_valid", 32'(res_valid), 0);
        check("release_ovf", 32'(res_ovf), 0);
        check("release_ready", 32'(tok_ready), 1);
      end else begin
        n = 0;
        do begin @(negedge clk); n++; end while (!tok_ready && n < 20);
        check(q[i].t == 2'b00 ? "push_cycles" : "binop_cycles", n, q[i].t == 2'b00 ? 2 : 5);
      end
    end
  endtask

  task automatic gen(output tok_t q[$]);
    int d, len, r;
    d = 0;
    len = $urandom_range(1, 14);
    q.delete();
    for (int k = 0; k < len; k++) begin
      r = $urandom_range(0, 99);
      if (r < 4 || (r >= 8 && d >= DEPTH) || (r >= 54 && d >= 2)) begin
        q.push_back(mk(2'($urandom_range(1, 2)), 0));
        if (d >= 2) d--;
      end else begin
        q.push_back(mk(2'b00, r[0] ? $urandom_range(0, 255) : $urandom_range(0, 6)));
        d++;
      end
    end
    while (d > 1) begin q.push_back(mk(2'($urandom_range(1, 2)), 0)); d--; end
    if (d == 0) q.push_back(mk(2'b00, $urandom_range(0, 255)));
    if ($urandom_range(0, 19) == 0) q.push_back(mk(2'b00, 1));
    q.push_back(mk(2'b11, 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tok_t q[$];
    rst = 1'b1; clear = 1'b0; tok_valid = 1'b0; res_ready = 1'b0;
    tok_type = 2'b00; tok_data = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(tok_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {res_valid, res_ovf, err, err_code, alu_opcode}, 0);
    check("reset_res_data", 32'(res_data), 0);
    check("reset_alu_data", 32'(alu_data), 0);
    check("reset_depth", 32'(depth), 0);
    check("reset_tok_ready", 32'(tok_ready), 1);

    // 3 4 + 5 * end = 35
    q = '{mk(0, 3), mk(0, 4), mk(1, 0), mk(0, 5), mk(2, 0), mk(3, 0)};
    run_expr(q, 1);
    // 100 100 + end wraps to -56 with overflow, then 1 end without
    q = '{mk(0, 100), mk(0, 100), mk(1, 0), mk(3, 0)};
    run_expr(q, 2);
    q = '{mk(0, 1), mk(3, 0)};
    run_expr(q, 0);
    // 7 + underflows
    q = '{mk(0, 7), mk(1, 0)};
    run_expr(q, 0);
    // nine operands overflow the stack
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(mk(0, i + 1));
    run_expr(q, 0);
    // 1 2 end has a bad final depth
    q = '{mk(0, 1), mk(0, 2), mk(3, 0)};
    run_expr(q, 0);
    // clear mid-expression at depth 3
    q = '{mk(0, -3), mk(0, 9), mk(0, 27)};
    run_expr(q, 0);
    do_clear(3);
    // result held with res_ready low for 10 cycles
    q = '{mk(0, -7), mk(0, 6), mk(2, 0), mk(3, 0)};
    run_expr(q, 10);

    // reset in the middle of a binary operation aborts without draining
    q = '{mk(0, 5), mk(0, 6), mk(1, 0)};
    send(q[0]); send(q[1]); send(q[2]);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(tok_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_depth", 32'(depth), 0);
    check("midrst_state", {res_valid, err, alu_opcode}, 0);
    check("midrst_ready_after", 32'(tok_ready), 1);
    check("midrst_alu_sp", sp, 0);

    for (int k = 0; k < 40; k++) begin
      gen(q);
      run_expr(q, $urandom_range(0, 3));
    end

    check("alu_protocol", alu_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
